cam_dvp_capture: RTL

- Parametrised second-generation DVP camera receiver. Runs in the cmos_pclk domain between the sensor pins and the frame-buffer write path.
- Assembles BYTES_PER_PIX sensor beats into one pixel word. Generates pixel x/y coordinates and frame start/end strobes.
- Discards a configurable number of frames after configuration completes.
- Supports continuous capture or single-shot capture gated by a held-low frame request.

---
 rtl/cam_dvp_capture.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/cam_dvp_capture.sv
// DVP camera receiver: packs sensor beats into pixels with x/y coordinates and
// frame strobes, discarding the first frames after configuration and supporting single-shot capture.
//
// state   | meaning
// IDLE    | waiting for synchronised cfg_done
// SKIP    | discarding SKIP_FRAMES frames after configuration
// ARMED   | waiting for a frame start with a capture request
// CAPTURE | assembling and presenting pixels
module cam_dvp_capture #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int SKIP_FRAMES   = 1,
  parameter int REQ_HOLD      = 100,
  parameter int X_W           = 12,
  parameter int Y_W           = 12
) (
  input  logic                            cmos_pclk,
  input  logic                            rst,
  input  logic [DATA_W-1:0]               cmos_data,
  input  logic                            cmos_href,
  input  logic                            cmos_vsyn,
  input  logic                            cfg_done,
  input  logic                            frame_en,
  input  logic                            cont_mode,
  output logic [DATA_W*BYTES_PER_PIX-1:0] pix_data,
  output logic                            pix_en,
  output logic [X_W-1:0]                  pix_x,
  output logic [Y_W-1:0]                  pix_y,
  output logic                            frame_start,
  output logic                            frame_end,
  output logic                            busy,
  output logic                            line_err
);

  localparam int PIX_W = DATA_W * BYTES_PER_PIX;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SKIP    = 2'd1;
  localparam logic [1:0] ST_ARMED   = 2'd2;
  localparam logic [1:0] ST_CAPTURE = 2'd3;

  localparam logic [1:0]  LAST_IDX  = 2'(BYTES_PER_PIX - 1);
  localparam logic [7:0]  SKIP_INIT = 8'(SKIP_FRAMES);
  localparam logic [15:0] REQ_MAX   = 16'(REQ_HOLD);

  logic             sync1_q, done_s_q;
  logic             vs_d1_q, vs_d2_q, href_d1_q;
  logic [1:0]       state_q, state_d;
  logic [7:0]       skip_q, skip_d;
  logic [15:0]      req_cnt_q, req_cnt_d;
  logic             req_pend_q, req_pend_d;
  logic [1:0]       idx_q, idx_d;
  logic [PIX_W-1:0] asm_q, asm_d;
  logic [PIX_W-1:0] pix_data_q, pix_data_d;
  logic             pix_en_q, pix_en_d;
  logic [X_W-1:0]   x_q, x_d, pix_x_q, pix_x_d;
  logic [Y_W-1:0]   y_q, y_d, pix_y_q, pix_y_d;
  logic             line_pix_q, line_pix_d;
  logic             fs_q, fs_d, fe_q, fe_d;
  logic             line_err_q, line_err_d;

  logic             vs_fall, vs_rise, hr_fall, active;
  logic [PIX_W-1:0] asm_shift;

  assign vs_fall   = vs_d2_q & ~vs_d1_q;
  assign vs_rise   = ~vs_d2_q & vs_d1_q;
  assign hr_fall   = href_d1_q & ~cmos_href;
  // Gating on done_s as well stops pixel output one cycle before the FSM leaves CAPTURE.
  assign active    = (state_q == ST_CAPTURE) & done_s_q;
  assign asm_shift = (asm_q << DATA_W) | PIX_W'(cmos_data);

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    fs_d    = 1'b0;
    fe_d    = 1'b0;
    if (!done_s_q) begin
      state_d = ST_IDLE;
      skip_d  = SKIP_INIT;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = (SKIP_INIT != 8'd0) ? ST_SKIP : ST_ARMED;
        ST_SKIP: begin
          if (vs_fall) begin
            skip_d = (skip_q != 8'd0) ? skip_q - 8'd1 : 8'd0;
            if (skip_q <= 8'd1) state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (vs_fall && (cont_mode || req_pend_q)) begin
            state_d = ST_CAPTURE;
            fs_d    = 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (vs_rise) begin
            state_d = ST_ARMED;
            fe_d    = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    req_cnt_d  = req_cnt_q;
    req_pend_d = req_pend_q;
    if (fs_d && !cont_mode) req_pend_d = 1'b0;
    if (frame_en) begin
      req_cnt_d = 16'd0;
    end else if (req_cnt_q != REQ_MAX) begin
      req_cnt_d = req_cnt_q + 16'd1;
      if (req_cnt_q == REQ_MAX - 16'd1) req_pend_d = 1'b1;
    end
  end

  always_comb begin
    idx_d      = idx_q;
    asm_d      = asm_q;
    x_d        = x_q;
    y_d        = y_q;
    line_pix_d = line_pix_q;
    pix_en_d   = 1'b0;
    pix_data_d = pix_data_q;
    pix_x_d    = pix_x_q;
    pix_y_d    = pix_y_q;
    line_err_d = line_err_q;
    if (!active) begin
      idx_d      = 2'd0;
      asm_d      = '0;
      x_d        = '0;
      y_d        = '0;
      line_pix_d = 1'b0;
    end else if (cmos_href) begin
      asm_d = asm_shift;
      if (idx_q == LAST_IDX) begin
        idx_d      = 2'd0;
        pix_en_d   = 1'b1;
        pix_data_d = asm_shift;
        pix_x_d    = x_q;
        pix_y_d    = y_q;
        x_d        = x_q + X_W'(1);
        line_pix_d = 1'b1;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end else if (hr_fall) begin
      if (idx_q != 2'd0) line_err_d = 1'b1;
      idx_d      = 2'd0;
      asm_d      = '0;
      x_d        = '0;
      line_pix_d = 1'b0;
      if (line_pix_q) y_d = y_q + Y_W'(1);
    end
  end

  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      done_s_q   <= 1'b0;
      vs_d1_q    <= 1'b0;
      vs_d2_q    <= 1'b0;
      href_d1_q  <= 1'b0;
      state_q    <= ST_IDLE;
      skip_q     <= SKIP_INIT;
      req_cnt_q  <= 16'd0;
      req_pend_q <= 1'b0;
      idx_q      <= 2'd0;
      asm_q      <= '0;
      pix_data_q <= '0;
      pix_en_q   <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      line_pix_q <= 1'b0;
      fs_q       <= 1'b0;
      fe_q       <= 1'b0;
      line_err_q <= 1'b0;
    end else begin
      sync1_q    <= cfg_done;
      done_s_q   <= sync1_q;
      vs_d1_q    <= cmos_vsyn;
      vs_d2_q    <= vs_d1_q;
      href_d1_q  <= cmos_href;
      state_q    <= state_d;
      skip_q     <= skip_d;
      req_cnt_q  <= req_cnt_d;
      req_pend_q <= req_pend_d;
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      pix_data_q <= pix_data_d;
      pix_en_q   <= pix_en_d;
      x_q        <= x_d;
      y_q        <= y_d;
      pix_x_q    <= pix_x_d;
      pix_y_q    <= pix_y_d;
      line_pix_q <= line_pix_d;
      fs_q       <= fs_d;
      fe_q       <= fe_d;
      line_err_q <= line_err_d;
    end
  end

  assign pix_data    = pix_data_q;
  assign pix_en      = pix_en_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign busy        = (state_q == ST_CAPTURE);
  assign line_err    = line_err_q;

endmodule
